// File: rtl/ov7670_ctrl_pkg.sv
// Shared types and the default OV7670 register table for the camera sequencer.
// The table sets up RGB565 output at QVGA; a COM7 soft reset goes out first.
package ov7670_ctrl_pkg;

  typedef enum logic [2:0] {
    RESET_WAIT    = 3'd0,
    IDLE          = 3'd1,
    CFG_ISSUE     = 3'd2,
    CFG_ACK       = 3'd3,
    CFG_DONE_WAIT = 3'd4,
    CAP_SYNC      = 3'd5,
    CAP_RUN       = 3'd6,
    CAP_DONE      = 3'd7
  } ctrl_state_e;

  typedef struct packed {
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [31:0] delay;
  } cfg_entry_t;

  localparam logic [7:0] DELAY_ONLY_ADDR = 8'hFF;
  localparam int         CFG_TABLE_LEN   = 16;

  // Entry 1 lets the sensor settle after the COM7 soft reset
  localparam cfg_entry_t CFG_TABLE [CFG_TABLE_LEN] = '{
    '{8'h12, 8'h80, 32'd0},
    '{8'hFF, 8'h00, 32'd50},
    '{8'h12, 8'h14, 32'd0},
    '{8'h40, 8'hD0, 32'd0},
    '{8'h8C, 8'h00, 32'd0},
    '{8'h11, 8'h01, 32'd10},
    '{8'h0C, 8'h04, 32'd0},
    '{8'h3E, 8'h19, 32'd0},
    '{8'h70, 8'h3A, 32'd0},
    '{8'h71, 8'h35, 32'd0},
    '{8'h72, 8'h11, 32'd0},
    '{8'h73, 8'hF1, 32'd0},
    '{8'hA2, 8'h02, 32'd0},
    '{8'h3A, 8'h04, 32'd0},
    '{8'h13, 8'hE7, 32'd0},
    '{8'h32, 8'h80, 32'd0}
  };

  // Indices past the table read as zero-length delay entries, i.e. no-ops
  function automatic cfg_entry_t cfg_lookup(input logic [7:0] idx);
    cfg_entry_t entry;
    if (idx < 8'(CFG_TABLE_LEN)) begin
      entry = CFG_TABLE[idx[3:0]];
    end else begin
      entry = '{addr: DELAY_ONLY_ADDR, data: 8'h00, delay: 32'd0};
    end
    return entry;
  endfunction

endpackage

// File: rtl/ov7670_cfg_rom.sv
// Configuration table ROM with a registered read port (one cycle latency).
module ov7670_cfg_rom
  import ov7670_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  idx,
  output logic [47:0] entry
);

  // Registered table read
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      entry <= 48'd0;
    end else begin
      entry <= cfg_lookup(idx);
    end
  end

endmodule

// File: rtl/ov7670_ctrl.sv
// OV7670 subsystem sequencer: walks the register table over I2C, then schedules
// single-shot or continuous frame captures aligned to the camera VSYNC trigger.
module ov7670_ctrl
  import ov7670_ctrl_pkg::*;
#(
  parameter int NUM_REGS      = 64,
  parameter int ACK_TIMEOUT   = 1024,
  parameter int VSYNC_TIMEOUT = 2_000_000,
  parameter int AUTO_CFG      = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cfg_req_i,
  input  logic        cap_req_i,
  input  logic        cont_i,
  output logic        i2c_start_en_o,
  output logic [7:0]  i2c_addr_o,
  output logic [7:0]  i2c_data_o,
  output logic [31:0] delay_o,
  input  logic        i2c_ready_i,
  output logic        pxl_start_en_o,
  input  logic        pxl_idle_i,
  input  logic        cam_vsync_trig_i,
  output logic        cont_read_o,
  output logic        cfg_done_o,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic [15:0] frame_cnt_o,
  output logic        err_o,
  output logic [2:0]  state_o
);

  localparam logic [7:0]  LAST_IDX  = 8'(NUM_REGS - 1);
  localparam logic [31:0] ACK_TMO   = 32'(ACK_TIMEOUT);
  localparam logic [31:0] VSYNC_TMO = 32'(VSYNC_TIMEOUT);

  ctrl_state_e state_r;
  logic [7:0]  idx_r;
  logic [31:0] wait_cnt_r;
  logic        rd_wait_r;
  logic        seen_low_r;
  logic        cfg_pend_r;
  logic        cap_pend_r;
  logic [47:0] rom_data_s;
  cfg_entry_t  rom_q_s;
  logic        cfg_want_s;
  logic        cap_want_s;
  logic        ack_tmo_s;
  logic        vsync_tmo_s;
  logic        dly_done_s;
  logic        cfg_step_s;
  logic        tmo_s;

  ov7670_cfg_rom u_cfg_rom (
    .clk    (clk),
    .resetn (resetn),
    .idx    (idx_r),
    .entry  (rom_data_s)
  );

  assign rom_q_s     = rom_data_s;
  assign cfg_want_s  = cfg_req_i | cfg_pend_r;
  assign cap_want_s  = cap_req_i | cap_pend_r;
  assign ack_tmo_s   = (wait_cnt_r >= ACK_TMO);
  assign vsync_tmo_s = (wait_cnt_r >= VSYNC_TMO);
  assign dly_done_s  = ((wait_cnt_r + 32'd1) >= rom_q_s.delay);
  assign state_o     = state_r;

  // Table-step and timeout decisions; a success edge always beats expiry
  always_comb begin
    cfg_step_s = 1'b0;
    tmo_s      = 1'b0;
    case (state_r)
      CFG_ACK: begin
        cfg_step_s = seen_low_r & i2c_ready_i;
        tmo_s      = ack_tmo_s & (seen_low_r ? ~i2c_ready_i : i2c_ready_i);
      end
      CFG_DONE_WAIT: cfg_step_s = dly_done_s;
      CAP_SYNC:      tmo_s      = vsync_tmo_s & ~cam_vsync_trig_i;
      CAP_RUN:       tmo_s      = ack_tmo_s & (seen_low_r ? ~pxl_idle_i : pxl_idle_i);
      default: begin
        cfg_step_s = 1'b0;
        tmo_s      = 1'b0;
      end
    endcase
  end

  // Sequencer state, request latches and all registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r        <= RESET_WAIT;
      idx_r          <= 8'd0;
      wait_cnt_r     <= 32'd0;
      rd_wait_r      <= 1'b0;
      seen_low_r     <= 1'b0;
      cfg_pend_r     <= 1'b0;
      cap_pend_r     <= 1'b0;
      i2c_start_en_o <= 1'b0;
      i2c_addr_o     <= 8'd0;
      i2c_data_o     <= 8'd0;
      delay_o        <= 32'd0;
      pxl_start_en_o <= 1'b0;
      cont_read_o    <= 1'b0;
      cfg_done_o     <= 1'b0;
      busy_o         <= 1'b0;
      frame_done_o   <= 1'b0;
      frame_cnt_o    <= 16'd0;
      err_o          <= 1'b0;
    end else begin
      i2c_start_en_o <= 1'b0;
      pxl_start_en_o <= 1'b0;
      frame_done_o   <= 1'b0;
      busy_o         <= (state_r != IDLE);
      wait_cnt_r     <= wait_cnt_r + 32'd1;
      if (cfg_req_i) cfg_pend_r <= 1'b1;
      if (cap_req_i) cap_pend_r <= 1'b1;

      case (state_r)
        RESET_WAIT: begin
          if (i2c_ready_i) begin
            if (AUTO_CFG != 0) begin
              state_r    <= CFG_ISSUE;
              idx_r      <= 8'd0;
              rd_wait_r  <= 1'b0;
              cfg_done_o <= 1'b0;
            end else begin
              state_r <= IDLE;
            end
          end
        end
        IDLE: begin
          if (cfg_want_s) begin
            cfg_pend_r <= 1'b0;
            err_o      <= 1'b0;
            state_r    <= CFG_ISSUE;
            idx_r      <= 8'd0;
            rd_wait_r  <= 1'b0;
            cfg_done_o <= 1'b0;
          end else if (cap_want_s || cont_i) begin
            cap_pend_r <= 1'b0;
            if (cfg_done_o) begin
              state_r     <= CAP_SYNC;
              cont_read_o <= cont_i;
              wait_cnt_r  <= 32'd0;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        // First cycle lets the ROM output catch up with idx_r
        CFG_ISSUE: begin
          if (!rd_wait_r) begin
            rd_wait_r <= 1'b1;
          end else begin
            rd_wait_r  <= 1'b0;
            wait_cnt_r <= 32'd0;
            if (rom_q_s.addr == DELAY_ONLY_ADDR) begin
              state_r <= CFG_DONE_WAIT;
            end else begin
              i2c_addr_o     <= rom_q_s.addr;
              i2c_data_o     <= rom_q_s.data;
              delay_o        <= rom_q_s.delay;
              i2c_start_en_o <= 1'b1;
              seen_low_r     <= 1'b0;
              state_r        <= CFG_ACK;
            end
          end
        end
        CFG_ACK: begin
          if (!seen_low_r && !i2c_ready_i) begin
            seen_low_r <= 1'b1;
            wait_cnt_r <= 32'd0;
          end
        end
        CFG_DONE_WAIT: begin
          seen_low_r <= 1'b0;
        end
        CAP_SYNC: begin
          if (cam_vsync_trig_i) begin
            pxl_start_en_o <= 1'b1;
            seen_low_r     <= 1'b0;
            wait_cnt_r     <= 32'd0;
            state_r        <= CAP_RUN;
          end
        end
        CAP_RUN: begin
          if (!seen_low_r) begin
            if (!pxl_idle_i) begin
              seen_low_r <= 1'b1;
              wait_cnt_r <= 32'd0;
            end
          end else if (pxl_idle_i) begin
            state_r <= CAP_DONE;
          end
        end
        CAP_DONE: begin
          frame_done_o <= 1'b1;
          frame_cnt_o  <= frame_cnt_o + 16'd1;
          if (cont_i && !cfg_want_s) begin
            state_r    <= CAP_SYNC;
            wait_cnt_r <= 32'd0;
          end else begin
            cont_read_o <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase

      if (cfg_step_s) begin
        if (idx_r == LAST_IDX) begin
          idx_r      <= 8'd0;
          cfg_done_o <= 1'b1;
          state_r    <= IDLE;
        end else begin
          idx_r     <= idx_r + 8'd1;
          rd_wait_r <= 1'b0;
          state_r   <= CFG_ISSUE;
        end
      end

      if (tmo_s) begin
        err_o       <= 1'b1;
        cont_read_o <= 1'b0;
        state_r     <= IDLE;
        if (state_r == CFG_ACK) begin
          cfg_done_o <= 1'b0;
          idx_r      <= 8'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ov7670_ctrl.sv
// Directed bench for ov7670_ctrl with small I2C-engine and pixel-binner models.
module tb_ov7670_ctrl;

  localparam logic [2:0] ST_IDLE     = 3'd1;
  localparam logic [2:0] ST_CAP_SYNC = 3'd5;
  localparam logic [2:0] ST_CAP_RUN  = 3'd6;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cfg_req_i, cap_req_i, cont_i;
  logic        i2c_start_en_o;
  logic [7:0]  i2c_addr_o, i2c_data_o;
  logic [31:0] delay_o;
  logic        i2c_ready_i;
  logic        pxl_start_en_o;
  logic        pxl_idle_i;
  logic        cam_vsync_trig_i;
  logic        cont_read_o, cfg_done_o, busy_o, frame_done_o, err_o;
  logic [15:0] frame_cnt_o;
  logic [2:0]  state_o;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic        i2c_stuck = 1'b0;
  int          i2c_busy = 0;
  int          pxl_busy = 0;
  logic [47:0] strb_q[$];
  int          strb_t[$];
  int          pxl_cnt = 0;
  int          pxl_t = 0;
  int          fd_cnt = 0;
  int          fd_t = 0;
  int          base;

  // Expected write sequence for NUM_REGS=6 (entry 1 is a delay-only entry)
  logic [47:0] exp_wr [5] = '{
    {8'h12, 8'h80, 32'd0},
    {8'h12, 8'h14, 32'd0},
    {8'h40, 8'hD0, 32'd0},
    {8'h8C, 8'h00, 32'd0},
    {8'h11, 8'h01, 32'd10}
  };

  ov7670_ctrl #(
    .NUM_REGS      (6),
    .ACK_TIMEOUT   (16),
    .VSYNC_TIMEOUT (500),
    .AUTO_CFG      (1)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .cfg_req_i        (cfg_req_i),
    .cap_req_i        (cap_req_i),
    .cont_i           (cont_i),
    .i2c_start_en_o   (i2c_start_en_o),
    .i2c_addr_o       (i2c_addr_o),
    .i2c_data_o       (i2c_data_o),
    .delay_o          (delay_o),
    .i2c_ready_i      (i2c_ready_i),
    .pxl_start_en_o   (pxl_start_en_o),
    .pxl_idle_i       (pxl_idle_i),
    .cam_vsync_trig_i (cam_vsync_trig_i),
    .cont_read_o      (cont_read_o),
    .cfg_done_o       (cfg_done_o),
    .busy_o           (busy_o),
    .frame_done_o     (frame_done_o),
    .frame_cnt_o      (frame_cnt_o),
    .err_o            (err_o),
    .state_o          (state_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  function automatic logic [63:0] ctl_outs();
    return {38'd0, i2c_start_en_o, pxl_start_en_o, cont_read_o, cfg_done_o, busy_o,
            frame_done_o, err_o, state_o, frame_cnt_o};
  endfunction

  function automatic logic [63:0] bus_outs();
    return {16'd0, i2c_addr_o, i2c_data_o, delay_o};
  endfunction

  // I2C engine: ready drops for 10 cycles after each strobe unless stuck
  initial begin
    i2c_ready_i = 1'b1;
    forever begin
      @(negedge clk);
      if (i2c_start_en_o) begin
        strb_q.push_back({i2c_addr_o, i2c_data_o, delay_o});
        strb_t.push_back(cyc);
        if (!i2c_stuck) begin
          i2c_ready_i = 1'b0;
          i2c_busy    = 10;
        end
      end else if (i2c_busy > 0) begin
        i2c_busy--;
        if (i2c_busy == 0) i2c_ready_i = 1'b1;
      end
    end
  end

  // Pixel binner: idle drops for 12 cycles after each start
  initial begin
    pxl_idle_i = 1'b1;
    forever begin
      @(negedge clk);
      if (pxl_start_en_o) begin
        pxl_cnt++;
        pxl_t      = cyc;
        pxl_idle_i = 1'b0;
        pxl_busy   = 12;
      end else if (pxl_busy > 0) begin
        pxl_busy--;
        if (pxl_busy == 0) pxl_idle_i = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (frame_done_o) begin
        fd_cnt++;
        fd_t = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic pulse_vsync();
    cam_vsync_trig_i = 1'b1;
    step();
    cam_vsync_trig_i = 1'b0;
  endtask

  task automatic wait_cfg_done(input string tag);
    for (int t = 0; t < 600 && !cfg_done_o; t++) step();
    check_eq(tag, cfg_done_o, 1'b1);
  endtask

  initial begin
    resetn = 1'b0;
    cfg_req_i = 1'b0;
    cap_req_i = 1'b0;
    cont_i = 1'b0;
    cam_vsync_trig_i = 1'b0;
    step(3);
    check_eq("rst_ctl", ctl_outs(), 64'd0);
    check_eq("rst_bus", bus_outs(), 64'd0);

    // Automatic configuration after reset release
    resetn = 1'b1;
    wait_cfg_done("cfg_done");
    check_eq("strobe_count", strb_q.size(), 5);
    for (int i = 0; i < 5; i++) check_eq($sformatf("write%0d", i), strb_q[i], exp_wr[i]);
    check_eq("gap_delay_entry", strb_t[1] - strb_t[0], 65);
    check_eq("gap_normal", strb_t[2] - strb_t[1], 13);
    step(2);
    check_eq("idle_state", state_o, ST_IDLE);
    check_eq("idle_busy", busy_o, 1'b0);
    check_eq("idle_err", err_o, 1'b0);

    // Single-shot capture
    cap_req_i = 1'b1;
    step();
    cap_req_i = 1'b0;
    step(4);
    check_eq("cap_sync_state", state_o, ST_CAP_SYNC);
    check_eq("pxl_before_vsync", pxl_start_en_o, 1'b0);
    pulse_vsync();
    check_eq("pxl_after_vsync", pxl_start_en_o, 1'b1);
    for (int t = 0; t < 100 && fd_cnt == 0; t++) step();
    check_eq("frame_latency", fd_t - pxl_t, 14);
    check_eq("frame_cnt_1", frame_cnt_o, 16'd1);
    step(3);
    check_eq("frame_pulses_1", fd_cnt, 1);
    check_eq("single_back_idle", state_o, ST_IDLE);

    // Continuous capture, cont_i dropped during the third frame
    cont_i = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int t = 0; t < 50 && state_o != ST_CAP_SYNC; t++) step();
      check_eq($sformatf("cont_sync%0d", f), state_o, ST_CAP_SYNC);
      check_eq($sformatf("cont_read_on%0d", f), cont_read_o, 1'b1);
      step(3);
      base = fd_cnt;
      pulse_vsync();
      if (f == 2) begin
        step(4);
        cont_i = 1'b0;
      end
      for (int t = 0; t < 100 && fd_cnt == base; t++) step();
      check_eq($sformatf("cont_read_at_done%0d", f), cont_read_o, (f < 2) ? 1'b1 : 1'b0);
    end
    step(2);
    check_eq("frame_cnt_4", frame_cnt_o, 16'd4);
    check_eq("frame_pulses_4", fd_cnt, 4);
    check_eq("cont_end_idle", state_o, ST_IDLE);

    // Reset in the middle of a frame, then automatic reconfiguration
    cap_req_i = 1'b1;
    step();
    cap_req_i = 1'b0;
    step(3);
    pulse_vsync();
    step(4);
    check_eq("mid_run_state", state_o, ST_CAP_RUN);
    resetn = 1'b0;
    #1;
    check_eq("midrst_ctl", ctl_outs(), 64'd0);
    check_eq("midrst_bus", bus_outs(), 64'd0);
    strb_q.delete();
    strb_t.delete();
    step(2);
    resetn = 1'b1;
    wait_cfg_done("recfg_done");
    check_eq("recfg_count", strb_q.size(), 5);
    check_eq("recfg_first", strb_q[0], exp_wr[0]);
    check_eq("recfg_frame_cnt", frame_cnt_o, 16'd0);
    step(2);

    // I2C engine never acknowledges: timeout aborts the sequence
    i2c_stuck = 1'b1;
    base = strb_q.size();
    cfg_req_i = 1'b1;
    step();
    cfg_req_i = 1'b0;
    for (int t = 0; t < 20 && strb_q.size() == base; t++) step();
    check_eq("tmo_strobe", strb_q.size(), base + 1);
    for (int t = 0; t < 50 && !err_o; t++) step();
    check_eq("tmo_latency", cyc - strb_t[$], 17);
    check_eq("tmo_state", state_o, ST_IDLE);
    check_eq("tmo_cfg_done", cfg_done_o, 1'b0);

    // Capture without a valid configuration is dropped
    base = pxl_cnt;
    cap_req_i = 1'b1;
    step();
    cap_req_i = 1'b0;
    step(5);
    check_eq("drop_no_pxl", pxl_cnt, base);
    check_eq("drop_state", state_o, ST_IDLE);
    check_eq("drop_busy", busy_o, 1'b0);
    check_eq("drop_err", err_o, 1'b1);

    // Accepted cfg request clears the sticky error and reconfigures
    i2c_stuck = 1'b0;
    cfg_req_i = 1'b1;
    step();
    cfg_req_i = 1'b0;
    step();
    check_eq("err_cleared", err_o, 1'b0);
    wait_cfg_done("final_cfg_done");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
